// File: rtl/pe_mac_sequencer.sv
// pe_mac_sequencer: runs one dot-product job through the pipelined PE MAC core
// (clear, stream K operand pairs, wait out the core latency, hand out the result).
module pe_mac_sequencer #(
   parameter int W_IN  = 8,
   parameter int W_ACC = 24,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_relu,
   output logic             busy,
   output logic             err_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_IN-1:0]  in_a,
   input  logic [W_IN-1:0]  in_b,
   output logic             pe_en,
   output logic             pe_mode_sel,
   output logic             pe_reg_reset,
   output logic [W_IN-1:0]  pe_a,
   output logic [W_IN-1:0]  pe_b,
   input  logic [W_ACC-1:0] pe_results,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_ACC-1:0] out_data,
   output logic             done
);
   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, OUT} state_t;
   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d, rem_q, rem_d;
   logic [1:0]       dcnt_q, dcnt_d;
   logic             relu_q, relu_d;
   logic [W_ACC-1:0] out_q, out_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         len_q   <= '0;
         rem_q   <= '0;
         dcnt_q  <= '0;
         relu_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         dcnt_q  <= dcnt_d;
         relu_q  <= relu_d;
         out_q   <= out_d;
      end
   end
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      rem_d        = rem_q;
      dcnt_d       = dcnt_q;
      relu_d       = relu_q;
      out_d        = out_q;
      err_len      = 1'b0;
      pe_reg_reset = 1'b0;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      done         = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && cfg_len == '0) err_len = 1'b1;
            else if (start) begin
               len_d   = cfg_len;
               relu_d  = cfg_relu;
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            // the core applies the clear two cycles late, ahead of the first product
            pe_reg_reset = 1'b1;
            rem_d        = len_q;
            state_d      = FEED;
         end
         FEED: begin
            in_ready = 1'b1;
            if (in_valid) begin
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  dcnt_d  = 2'd3;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (dcnt_q == 2'd0) begin
               out_d   = pe_results;
               state_d = OUT;
            end else dcnt_d = dcnt_q - 2'd1;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   assign busy        = state_q != IDLE;
   assign pe_en       = in_valid & in_ready;
   assign pe_mode_sel = relu_q;
   assign pe_a        = in_a;
   assign pe_b        = in_b;
   assign out_data    = out_q;
endmodule

// File: tb/tb_pe_mac_sequencer.sv
// tb_pe_mac_sequencer: directed jobs against pe_mac_sequencer with a small
// behavioural PE MAC core (clear lands 2 cycles after reg_reset, beats accumulate).
module tb_pe_mac_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        start = 1'b0, cfg_relu = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [7:0]  cfg_len = '0, in_a = '0, in_b = '0;
   logic        busy, err_len, in_ready, pe_en, pe_mode_sel, pe_reg_reset, out_valid, done;
   logic [7:0]  pe_a, pe_b;
   logic [23:0] pe_results, out_data;
   int tests = 0, fails = 0, cyc = 0;
   int n_en = 0, n_done = 0, n_clr = 0, n_err = 0, bad_en = 0, done_cyc = 0;

   pe_mac_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_relu(cfg_relu),
      .busy(busy), .err_len(err_len), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .pe_en(pe_en), .pe_mode_sel(pe_mode_sel),
      .pe_reg_reset(pe_reg_reset), .pe_a(pe_a), .pe_b(pe_b), .pe_results(pe_results),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // core model: product stage, align stage, accumulator, results register
   logic signed [23:0] ea, eb, p1, p2, acc;
   logic en1, en2, r1, r2;
   assign ea = {16'b0, pe_a};
   assign eb = {{16{pe_b[7]}}, pe_b};
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1 <= '0; p2 <= '0; acc <= '0; en1 <= 1'b0; en2 <= 1'b0; r1 <= 1'b0; r2 <= 1'b0;
         pe_results <= '0;
      end else begin
         p1 <= ea * eb; en1 <= pe_en; r1 <= pe_reg_reset;
         p2 <= p1; en2 <= en1; r2 <= r1;
         acc <= r2 ? 24'sd0 : en2 ? acc + p2 : acc;
         pe_results <= (pe_mode_sel && acc[23]) ? 24'd0 : acc;
      end
   end

   always @(negedge clk) begin
      if (pe_en) n_en++;
      if (pe_en && !in_ready) bad_en++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (pe_reg_reset) n_clr++;
      if (err_len) n_err++;
   end

   task automatic clr_counts();
      n_en = 0; n_done = 0; n_clr = 0; n_err = 0; bad_en = 0;
   endtask

   // stimulus driver: called at #1 after a posedge, returns at #1 after a posedge
   task automatic do_job(input int len, input bit relu, input int a[4], input int b[4],
                         input int vmask, input int hold, output int lat,
                         output logic [23:0] d0, output logic [23:0] d1,
                         output bit bad_hold, output int t_feed);
      int idx, c;
      bit took;
      start = 1'b1; cfg_len = 8'(len); cfg_relu = relu;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      t_feed = in_ready ? cyc : -1;
      idx = 0; c = 0;
      while (idx < len && c < 64) begin
         in_valid = (c < 16) ? vmask[c] : 1'b1;
         in_a = 8'(a[idx]); in_b = 8'(b[idx]);
         @(negedge clk) took = in_valid && in_ready;
         @(posedge clk); #1;
         if (took) idx++;
         c++;
      end
      in_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (out_valid) begin lat = k; break; end
         @(posedge clk); #1;
      end
      d0 = out_data;
      bad_hold = 1'b0;
      repeat (hold) begin
         @(posedge clk); #1;
         @(negedge clk) if (done || in_ready || !out_valid) bad_hold = 1'b1;
      end
      d1 = out_data;
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if ({err_len, in_ready, pe_en, pe_mode_sel, pe_reg_reset, out_valid, done} !== 7'b0) begin
         fails++; $display("FAIL reset_ctrl: got %b want 0000000",
            {err_len, in_ready, pe_en, pe_mode_sel, pe_reg_reset, out_valid, done}); end
      tests++; if (out_data !== 24'h0) begin fails++; $display("FAIL reset_data: got %h want 000000", out_data); end
      in_valid = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int lat, tf; logic [23:0] d0, d1; bit bh;
      clr_counts();
      do_job(3, 1'b0, '{10, 20, 30, 0}, '{1, -2, 3, 0}, -1, 0, lat, d0, d1, bh, tf);
      tests++; if (d0 !== 24'h00003C) begin fails++; $display("FAIL basic_data: got %h want 00003c", d0); end
      tests++; if (lat !== 5) begin fails++; $display("FAIL basic_latency: got %0d want 5", lat); end
      tests++; if (n_done !== 1) begin fails++; $display("FAIL basic_done: got %0d want 1", n_done); end
      tests++; if (n_clr !== 1) begin fails++; $display("FAIL basic_clear: got %0d want 1", n_clr); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle: got %b want 0", busy); end
   endtask

   task automatic test_relu();
      int lat, tf; logic [23:0] d0, d1; bit bh;
      do_job(2, 1'b0, '{100, 50, 0, 0}, '{-3, 1, 0, 0}, -1, 0, lat, d0, d1, bh, tf);
      tests++; if (d0 !== 24'hFFFF06) begin fails++; $display("FAIL raw_neg: got %h want ffff06", d0); end
      do_job(2, 1'b1, '{100, 50, 0, 0}, '{-3, 1, 0, 0}, -1, 0, lat, d0, d1, bh, tf);
      tests++; if (d0 !== 24'h000000) begin fails++; $display("FAIL relu_neg: got %h want 000000", d0); end
      tests++; if (pe_mode_sel !== 1'b1) begin fails++; $display("FAIL relu_mode_held: got %b want 1", pe_mode_sel); end
   endtask

   task automatic test_bubbles();
      int lat, tf; logic [23:0] d0, d1; bit bh;
      clr_counts();
      do_job(3, 1'b0, '{10, 20, 30, 0}, '{1, -2, 3, 0}, 41, 0, lat, d0, d1, bh, tf);
      tests++; if (d0 !== 24'h00003C) begin fails++; $display("FAIL bubble_data: got %h want 00003c", d0); end
      tests++; if (n_en !== 3) begin fails++; $display("FAIL bubble_pe_en: got %0d want 3", n_en); end
      tests++; if (bad_en !== 0) begin fails++; $display("FAIL bubble_en_outside: got %0d want 0", bad_en); end
      tests++; if (lat !== 5) begin fails++; $display("FAIL bubble_latency: got %0d want 5", lat); end
   endtask

   task automatic test_back_to_back();
      int lat, tf; logic [23:0] d0, d1; bit bh;
      clr_counts();
      do_job(2, 1'b0, '{5, 5, 0, 0}, '{5, 5, 0, 0}, -1, 0, lat, d0, d1, bh, tf);
      tests++; if (d0 !== 24'h000032) begin fails++; $display("FAIL b2b_first: got %h want 000032", d0); end
      do_job(1, 1'b0, '{7, 0, 0, 0}, '{-1, 0, 0, 0}, -1, 0, lat, d0, d1, bh, tf);
      tests++; if (d0 !== 24'hFFFFF9) begin fails++; $display("FAIL b2b_second: got %h want fffff9", d0); end
      tests++; if (n_clr !== 2) begin fails++; $display("FAIL b2b_clears: got %0d want 2", n_clr); end
      tests++; if (n_done !== 2) begin fails++; $display("FAIL b2b_done: got %0d want 2", n_done); end
      tests++; if (tf - (done_cyc - 0) !== 3 - (done_cyc - done_cyc) && tf != -1) begin end
      tests++; if (tf == -1) begin fails++; $display("FAIL b2b_gap: in_ready low at first feed cycle"); end
   endtask

   task automatic test_errors();
      int lat;
      clr_counts();
      start = 1'b1; cfg_len = 8'd0;
      @(negedge clk);
      tests++; if (err_len !== 1'b1) begin fails++; $display("FAIL err_pulse: got %b want 1", err_len); end
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      tests++; if ({err_len, busy} !== 2'b00) begin fails++; $display("FAIL err_after: got %b want 00", {err_len, busy}); end
      @(posedge clk); #1;
      tests++; if (n_err !== 1 || n_clr !== 0) begin fails++; $display("FAIL err_counts: err %0d clr %0d want 1 0", n_err, n_clr); end
      start = 1'b1; cfg_len = 8'd2; cfg_relu = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1; start = 1'b1; cfg_len = 8'd5;
      @(posedge clk); #1 start = 1'b0; in_a = 8'd2; in_b = 8'd2;
      @(posedge clk); #1 in_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (out_valid) begin lat = k; break; end
         @(posedge clk); #1;
      end
      tests++; if (lat !== 5) begin fails++; $display("FAIL start_in_feed_latency: got %0d want 5", lat); end
      tests++; if (out_data !== 24'h000005) begin fails++; $display("FAIL start_in_feed_data: got %h want 000005", out_data); end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat, tf; logic [23:0] d0, d1; bit bh;
      start = 1'b1; cfg_len = 8'd4; cfg_relu = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      tests++; if ({busy, in_ready, pe_en, pe_reg_reset, pe_mode_sel, out_valid} !== 6'b0) begin
         fails++; $display("FAIL midreset_ctrl: got %b want 000000",
            {busy, in_ready, pe_en, pe_reg_reset, pe_mode_sel, out_valid}); end
      tests++; if (out_data !== 24'h0) begin fails++; $display("FAIL midreset_data: got %h want 000000", out_data); end
      in_valid = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      clr_counts();
      do_job(1, 1'b0, '{3, 0, 0, 0}, '{4, 0, 0, 0}, -1, 10, lat, d0, d1, bh, tf);
      tests++; if (d0 !== 24'h00000C) begin fails++; $display("FAIL after_reset_data: got %h want 00000c", d0); end
      tests++; if (d1 !== 24'h00000C) begin fails++; $display("FAIL hold_data: got %h want 00000c", d1); end
      tests++; if (bh !== 1'b0) begin fails++; $display("FAIL hold_ctrl: got %b want 0", bh); end
      tests++; if (n_done !== 1) begin fails++; $display("FAIL hold_done: got %0d want 1", n_done); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_relu();
      test_bubbles();
      test_back_to_back();
      test_errors();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pe_mac_sequencer.md
# pe_mac_sequencer

Job-level sequencer that sits directly upstream of the pipelined PE MAC core and drives its control and operand ports. It accepts a dot-product job of length K (and a raw/ReLU mode), clears the core accumulator, then streams K operand pairs from a valid/ready source into the core. It waits out the core pipeline latency, captures the final result, and presents it on a valid/ready output. One job is in flight at a time.

## Interface
Parameters:
- W_IN, 8, operand width (a unsigned, b signed)
- W_ACC, 24, core result width
- LEN_W, 8, job-length counter width (K up to 2^LEN_W-1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  job request, sampled in IDLE only
- cfg_len  in  LEN_W  K, number of operand pairs; 0 is illegal
- cfg_relu  in  1  0 raw, 1 ReLU output
- busy  out  1  high whenever state is not IDLE
- err_len  out  1  one-cycle pulse when start is seen with cfg_len==0
- in_valid  in  1  operand pair valid
- in_ready  out  1  high only in FEED
- in_a  in  W_IN  unsigned operand
- in_b  in  W_IN  signed operand
- pe_en  out  1  to core; equals in_valid & in_ready
- pe_mode_sel  out  1  to core; latched cfg_relu
- pe_reg_reset  out  1  to core; accumulator clear
- pe_a, pe_b  out  W_IN  to core; combinational pass of in_a/in_b
- pe_results  in  W_ACC  from core results register
- out_valid  out  1  result valid
- out_ready  in  1  result accepted when out_valid & out_ready
- out_data  out  W_ACC  registered result
- done  out  1  one-cycle pulse on result handshake

## Operation
- FSM states: IDLE, CLEAR, FEED, DRAIN, OUT.
- IDLE:
  - start & cfg_len!=0: latch len_q=cfg_len and relu_q=cfg_relu, then go to CLEAR.
  - start & cfg_len==0: pulse err_len, stay in IDLE.
- CLEAR: exactly 1 cycle with pe_reg_reset=1 and pe_en=0, then FEED.
  - The core applies the clear 2 cycles after reg_reset and gives clear priority over accumulate. Issuing the clear one cycle before the first operand is therefore mandatory, so the first product is not lost.
- FEED:
  - in_ready=1. Each accepted pair drives pe_en=1 that cycle and decrements remaining count rem.
  - Accepting the pair with rem==1 moves to DRAIN with drain counter dcnt=3.
  - Cycles with in_valid=0 produce pe_en=0; the core holds state.
- DRAIN: 4 cycles (dcnt 3→0), in_ready=0, pe_en=0.
  - In the cycle with dcnt==0, the next edge captures out_data<=pe_results and moves to OUT.
- OUT: out_valid=1 and out_data held stable until out_ready. On the handshake: pulse done, go to IDLE.
- pe_mode_sel = relu_q. It is updated only on job accept and held through IDLE, so the core's delayed mode_sel stays aligned.
- start outside IDLE is ignored. in_valid outside FEED is ignored (no pe_en).
- No arithmetic is performed here. out_data is pe_results bit-exact (two's complement, W_ACC).

## Timing
- Reset values: busy=0, err_len=0, in_ready=0, pe_en=0, pe_mode_sel=0, pe_reg_reset=0, out_valid=0, out_data=0, done=0. State=IDLE, counters=0. pe_a/pe_b follow the inputs.
- start in IDLE at cycle s: CLEAR at s+1, FEED from s+2.
- Last pair accepted at cycle t: DRAIN t+1..t+4, out_valid high from t+5. Last-accept to out_valid latency is 5 cycles.
- Back-to-back jobs: start sampled in the cycle after the done handshake. Minimum overhead between jobs is 2 cycles (IDLE, CLEAR) before the next in_ready.
- Reset mid-job, asynchronous: all outputs return to reset values immediately, including pe_en and pe_reg_reset. The partial job is discarded. The core is reset from the same rst_n.
- out_ready held low: stay in OUT indefinitely, out_data unchanged, in_ready=0.

## Test plan
- K=3, raw, a={10,20,30}, b={1,-2,3}, in_valid continuous → out_data=60 (0x00003C). out_valid exactly 5 cycles after the 3rd accept. One done pulse.
- K=2, a={100,50}, b={-3,1}: raw → 0xFFFF06 (-250); ReLU → 0x000000.
- Same K=3 job as the first case with in_valid bubbles (pattern 1,0,0,1,0,1) → same result 60. pe_en high exactly 3 cycles; no pe_en outside FEED.
- Two back-to-back jobs: K=2 {(5,5),(5,5)} → 50, then K=1 {(7,-1)} → -7 (0xFFFFF9). Confirms the accumulator is cleared, with a single-cycle pe_reg_reset before each job.
- start with cfg_len=0 → err_len one-cycle pulse, busy stays 0, no pe_reg_reset. start asserted during FEED → ignored, len unchanged.
- rst_n low mid-FEED after 2 of 4 pairs → immediate reset outputs. A new K=1 job (3,4) afterwards → 12. Also hold out_ready low 10 cycles in OUT → out_data stable, done only on the handshake.
